// File: rtl/check_node_unit.sv
// Min-sum LDPC check-node unit: two-stage pipeline producing DC extrinsic messages per set.
// Optional offset min-sum magnitude correction is enabled by defining CNU_OFFSET_EN.
module check_node_unit #(
  parameter int DC     = 6,
  parameter int OFFSET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  input  logic [DC-1:0][5:0]  X,
  output logic [DC-1:0][4:0]  Y,
  output logic                out_valid,
  output logic                parity_fail,
  output logic [3:0]          min_out
);

  localparam int DATA_W = 4;
  localparam int IDX_W  = (DC > 1) ? $clog2(DC) : 1;

  if (DC < 2 || DC > 16) begin : g_bad_dc
    $error("check_node_unit: DC must be within 2..16");
  end
  if (OFFSET < 0 || OFFSET > 15) begin : g_bad_offset
    $error("check_node_unit: OFFSET must be within 0..15");
  end

`ifdef CNU_OFFSET_EN
  localparam logic [DATA_W-1:0] OFF_MAG = DATA_W'(OFFSET);
`endif

  // Magnitude post-processing: plain pass-through, or offset subtraction saturating at 0.
  function automatic logic [DATA_W-1:0] sel_mag(input logic [DATA_W-1:0] m);
`ifdef CNU_OFFSET_EN
    if (m > OFF_MAG) sel_mag = m - OFF_MAG;
    else             sel_mag = '0;
`else
    sel_mag = m;
`endif
  endfunction

  logic [DATA_W-1:0] min1_p0;
  logic [DATA_W-1:0] min2_p0;
  logic [IDX_W-1:0]  idx1_p0;
  logic              sgn_tot_p0;
  logic              par_p0;
  logic [DC-1:0]     sgn_p0;

  logic [DATA_W-1:0] min1_p1;
  logic [DATA_W-1:0] min2_p1;
  logic [IDX_W-1:0]  idx1_p1;
  logic              sgn_tot_p1;
  logic              par_p1;
  logic [DC-1:0]     sgn_p1;
  logic              vld_p1;

  // Stage 0: combinational scan; strict compares keep the lowest index for min1 and count duplicates into min2.
  always_comb begin
    min1_p0    = '1;
    min2_p0    = '1;
    idx1_p0    = '0;
    sgn_tot_p0 = 1'b0;
    par_p0     = 1'b0;
    sgn_p0     = '0;
    for (int i = 0; i < DC; i++) begin
      sgn_p0[i]  = X[i][4];
      sgn_tot_p0 = sgn_tot_p0 ^ X[i][4];
      par_p0     = par_p0 ^ X[i][5];
      if (X[i][3:0] < min1_p0) begin
        min2_p0 = min1_p0;
        min1_p0 = X[i][3:0];
        idx1_p0 = IDX_W'(i);
      end else if (X[i][3:0] < min2_p0) begin
        min2_p0 = X[i][3:0];
      end
    end
  end

  // Stage 1: register the set summary; advances on every enabled edge, valid or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min1_p1    <= '0;
      min2_p1    <= '0;
      idx1_p1    <= '0;
      sgn_tot_p1 <= 1'b0;
      par_p1     <= 1'b0;
      sgn_p1     <= '0;
      vld_p1     <= 1'b0;
    end else if (en) begin
      min1_p1    <= min1_p0;
      min2_p1    <= min2_p0;
      idx1_p1    <= idx1_p0;
      sgn_tot_p1 <= sgn_tot_p0;
      par_p1     <= par_p0;
      sgn_p1     <= sgn_p0;
      vld_p1     <= in_valid;
    end
  end

  // Stage 2: per-lane extrinsic outputs; data outputs only update on a valid set so they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y           <= '0;
      out_valid   <= 1'b0;
      parity_fail <= 1'b0;
      min_out     <= '0;
    end else if (en) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        for (int i = 0; i < DC; i++) begin
          Y[i][4]   <= sgn_tot_p1 ^ sgn_p1[i];
          Y[i][3:0] <= sel_mag((IDX_W'(i) == idx1_p1) ? min2_p1 : min1_p1);
        end
        parity_fail <= par_p1;
        min_out     <= min1_p1;
      end
    end
  end

endmodule

// File: tb/tb_check_node_unit.sv
// Directed bench for check_node_unit (DC=6): hand-computed vectors checked by immediate assertions.
module tb_check_node_unit;

  localparam int DC = 6;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en;
  logic                in_valid;
  logic [DC-1:0][5:0]  X;
  logic [DC-1:0][4:0]  Y;
  logic                out_valid;
  logic                parity_fail;
  logic [3:0]          min_out;

  int nvec = 0;
  int nerr = 0;

  check_node_unit #(.DC(DC), .OFFSET(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .X(X),
    .Y(Y), .out_valid(out_valid), .parity_fail(parity_fail), .min_out(min_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_mag(input int m);
`ifdef CNU_OFFSET_EN
    return (m > 1) ? m - 1 : 0;
`else
    return m;
`endif
  endfunction

  function automatic logic [DC-1:0][5:0] mk(input int m0, m1, m2, m3, m4, m5,
                                            input logic [5:0] sg, input logic [5:0] hd);
    logic [DC-1:0][5:0] r;
    int m[6];
    m = '{m0, m1, m2, m3, m4, m5};
    for (int i = 0; i < DC; i++) r[i] = {hd[i], sg[i], 4'(m[i])};
    return r;
  endfunction

  task automatic check_y(input string tag, input int e0, e1, e2, e3, e4, e5, input logic [5:0] sg);
    int e[6];
    e = '{e0, e1, e2, e3, e4, e5};
    for (int i = 0; i < DC; i++)
      chk($sformatf("%s_y%0d", tag, i), 32'(Y[i]), 32'({sg[i], 4'(exp_mag(e[i]))}));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; X = '0;
    repeat (2) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_parity", 32'(parity_fail), 32'd0);
    chk("rst_min_out", 32'(min_out), 32'd0);
    chk("rst_y", 32'(Y), 32'd0);
    #2 rst_n = 1'b1;
    en = 1'b1;

    // Min-sum with a duplicated minimum
    X = mk(5, 3, 9, 3, 12, 7, 6'b000000, 6'b000000); in_valid = 1'b1;
    step();
    in_valid = 1'b0; X = '0;
    chk("a_latency1", 32'(out_valid), 32'd0);
    step();
    chk("a_out_valid", 32'(out_valid), 32'd1);
    check_y("a", 3, 3, 3, 3, 3, 3, 6'b000000);
    chk("a_min_out", 32'(min_out), 32'd3);
    chk("a_parity", 32'(parity_fail), 32'd0);
    step();
    chk("a_valid_drop", 32'(out_valid), 32'd0);
    check_y("a_hold", 3, 3, 3, 3, 3, 3, 6'b000000);
    chk("a_hold_min", 32'(min_out), 32'd3);

    // Unique minimum at lane 1 gets min2; odd hard parity
    X = mk(4, 2, 8, 6, 15, 9, 6'b001001, 6'b000001); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("b_out_valid", 32'(out_valid), 32'd1);
    check_y("b", 2, 4, 2, 2, 2, 2, 6'b001001);
    chk("b_min_out", 32'(min_out), 32'd2);
    chk("b_parity", 32'(parity_fail), 32'd1);

    // Zero magnitudes and -0 contributing sign 1
    X = mk(0, 5, 7, 0, 9, 9, 6'b000001, 6'b000000); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check_y("c", 0, 0, 0, 0, 0, 0, 6'b111110);
    chk("c_min_out", 32'(min_out), 32'd0);

    // Offset vector (saturates to 0 when offset is built in)
    X = mk(1, 2, 8, 8, 8, 8, 6'b000000, 6'b000000); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check_y("d", 2, 1, 1, 1, 1, 1, 6'b000000);
    chk("d_min_out", 32'(min_out), 32'd1);

    // Back-to-back stream with a one-cycle stall
    X = mk(1, 9, 9, 9, 9, 9, 6'b000000, 6'b000000); in_valid = 1'b1;
    step();
    chk("s_e1_valid", 32'(out_valid), 32'd0);
    X = mk(9, 2, 9, 9, 9, 9, 6'b000000, 6'b100000);
    step();
    chk("s_e2_valid", 32'(out_valid), 32'd1);
    chk("s_e2_parity", 32'(parity_fail), 32'd0);
    chk("s_e2_min", 32'(min_out), 32'd1);
    en = 1'b0;
    X = mk(9, 9, 3, 9, 9, 9, 6'b000000, 6'b110000);
    step();
    chk("s_stall_valid", 32'(out_valid), 32'd1);
    chk("s_stall_parity", 32'(parity_fail), 32'd0);
    chk("s_stall_min", 32'(min_out), 32'd1);
    en = 1'b1;
    step();
    chk("s_e4_valid", 32'(out_valid), 32'd1);
    chk("s_e4_parity", 32'(parity_fail), 32'd1);
    chk("s_e4_min", 32'(min_out), 32'd2);
    check_y("s_e4", 2, 9, 2, 2, 2, 2, 6'b000000);
    in_valid = 1'b0;
    step();
    chk("s_e5_valid", 32'(out_valid), 32'd1);
    chk("s_e5_parity", 32'(parity_fail), 32'd0);
    chk("s_e5_min", 32'(min_out), 32'd3);
    step();
    chk("s_e6_valid", 32'(out_valid), 32'd0);
    chk("s_e6_min", 32'(min_out), 32'd3);

    // Asynchronous reset mid-stream discards in-flight sets
    X = mk(4, 2, 8, 6, 15, 9, 6'b001001, 6'b000001); in_valid = 1'b1;
    step();
    X = mk(5, 3, 9, 3, 12, 7, 6'b000000, 6'b000000);
    step();
    in_valid = 1'b0;
    chk("r_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_async_valid", 32'(out_valid), 32'd0);
    chk("r_async_parity", 32'(parity_fail), 32'd0);
    chk("r_async_min", 32'(min_out), 32'd0);
    chk("r_async_y", 32'(Y), 32'd0);
    step();
    #2 rst_n = 1'b1;
    step();
    chk("r_discard_valid", 32'(out_valid), 32'd0);
    X = mk(5, 3, 9, 3, 12, 7, 6'b000000, 6'b000000); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("r_latency1", 32'(out_valid), 32'd0);
    step();
    chk("r_first_valid", 32'(out_valid), 32'd1);
    chk("r_first_min", 32'(min_out), 32'd3);
    check_y("r", 3, 3, 3, 3, 3, 3, 6'b000000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
